// File: rtl/ctrl_unit4_pkg.sv
// ctrl_unit4 shared types: opcodes, ALU selects, FSM states and
// instruction field layout {op, rd, rs, imm}.
package ctrl_unit4_pkg;

  localparam int OP_W   = 4;
  localparam int REG_W  = 2;
  localparam int IMM_W  = 4;
  localparam int PC_W   = 4;
  localparam int ALU_W  = 3;
  localparam int IW     = OP_W + 2 * REG_W + IMM_W;

  localparam int IMM_LSB = 0;
  localparam int RS_LSB  = IMM_LSB + IMM_W;
  localparam int RD_LSB  = RS_LSB + REG_W;
  localparam int OP_LSB  = RD_LSB + REG_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_PASS = 4'h6,
    OP_LDI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_NOP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_PASS = 3'b110
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

endpackage

// File: rtl/ctrl_unit4_decode.sv
// Combinational opcode classifier. JMP/JZ are only recognised when
// CTRL_UNIT4_BRANCH_EN is defined; otherwise they decode as illegal.
module ctrl_unit4_decode
  import ctrl_unit4_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  output logic [ALU_W-1:0] alu_op_o,
  output logic             is_alu_o,
  output logic             is_ldi_o,
  output logic             is_jmp_o,
  output logic             is_jz_o,
  output logic             is_halt_o,
  output logic             is_illegal_o
);

  always_comb begin
    alu_op_o     = ALU_ADD;
    is_alu_o     = 1'b0;
    is_ldi_o     = 1'b0;
    is_jmp_o     = 1'b0;
    is_jz_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    unique case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_PASS: begin
        is_alu_o = 1'b1;
        alu_op_o = op_i[ALU_W-1:0];
      end
      OP_LDI:  is_ldi_o  = 1'b1;
      OP_NOP:  ;
      OP_HALT: is_halt_o = 1'b1;
`ifdef CTRL_UNIT4_BRANCH_EN
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_JZ:   is_jz_o   = 1'b1;
`endif
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit4.sv
// Multi-cycle fetch/decode/execute/writeback controller for a 4-bit
// datapath. Define CTRL_UNIT4_BRANCH_EN to enable JMP/JZ.
module ctrl_unit4
  import ctrl_unit4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_data,
  output logic [ALU_W-1:0] alu_op,
  input  logic [3:0]       alu_result,
  output logic [REG_W-1:0] rf_ra,
  output logic [REG_W-1:0] rf_rb,
  output logic [REG_W-1:0] rf_wa,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic [IMM_W-1:0] imm,
  output logic             zero,
  output logic             halted,
  output logic             illegal
);

  state_e state_q, state_d;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic             zero_q, zero_d;
  logic [REG_W-1:0] ra_q, ra_d;
  logic [REG_W-1:0] rb_q, rb_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  logic [ALU_W-1:0] dec_alu_op;
  logic dec_alu, dec_ldi, dec_jmp;
  logic dec_jz, dec_halt, dec_ill;
  logic br_taken;

  ctrl_unit4_decode u_dec (
    .op_i         (ir_q[OP_LSB +: OP_W]),
    .alu_op_o     (dec_alu_op),
    .is_alu_o     (dec_alu),
    .is_ldi_o     (dec_ldi),
    .is_jmp_o     (dec_jmp),
    .is_jz_o      (dec_jz),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_ill)
  );

  assign br_taken = dec_jmp | (dec_jz & zero_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    zero_d   = zero_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
    imem_req = 1'b0;
    alu_op   = ALU_ADD;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          zero_d  = 1'b0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ra_d    = ir_q[RD_LSB +: REG_W];
        rb_d    = ir_q[RS_LSB +: REG_W];
        imm_d   = ir_q[IMM_LSB +: IMM_W];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_op  = dec_alu_op;
        state_d = dec_halt ? S_HALT
                           : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // keep the select stable so the
        // ALU result is valid for the flag
        alu_op  = dec_alu_op;
        rf_we   = dec_alu | dec_ldi;
        rf_wsel = dec_ldi;
        illegal = dec_ill;
        if (dec_alu)
          zero_d = (alu_result == 4'd0);
        pc_d    = br_taken ? imm_q
                           : pc_q + 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      imm_q   <= imm_d;
    end
  end

  assign imem_addr = pc_q;
  assign rf_ra     = ra_q;
  assign rf_rb     = rb_q;
  assign rf_wa     = ra_q;
  assign imm       = imm_q;
  assign zero      = zero_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_unit4.sv
// Directed bench for ctrl_unit4 with a small instruction memory,
// register file and ALU model around the controller.
module tb_ctrl_unit4;

`ifdef CTRL_UNIT4_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_data;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic [1:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we, rf_wsel;
  logic [3:0]  imm;
  logic        zero, halted, illegal;

  int total = 0;
  int bad = 0;

  ctrl_unit4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_wa      (rf_wa),
    .rf_we      (rf_we),
    .rf_wsel    (rf_wsel),
    .imm        (imm),
    .zero       (zero),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // instruction memory with programmable ack delay
  logic [11:0] imem [16];
  int ack_dly = 0;
  int wait_cnt = 0;

  assign imem_ack  = imem_req && (wait_cnt == ack_dly);
  assign imem_data = imem[imem_addr];

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // register file and ALU model
  logic [3:0] rf [4];

  function automatic logic [3:0] alu_f(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = a & b;
      3'd3: alu_f = a | b;
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = a << 1;
      3'd6: alu_f = a;
      default: alu_f = 4'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, rf[rf_ra], rf[rf_rb]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wsel ? imm : alu_result;
    end
  end

  // monitors
  int n_we = 0, n_wsel = 0, n_ill = 0, n_sub = 0;
  int n_fetch = 0, run = 0, last_run = 0;
  logic [3:0] fa [1024];

  always @(negedge clk) begin
    if (rf_we) n_we <= n_we + 1;
    if (rf_we && rf_wsel) n_wsel <= n_wsel + 1;
    if (illegal) n_ill <= n_ill + 1;
    if (alu_op == 3'd1) n_sub <= n_sub + 1;
    if (imem_req) begin
      if (imem_ack) begin
        fa[n_fetch] <= imem_addr;
        n_fetch <= n_fetch + 1;
        last_run <= run + 1;
        run <= 0;
      end else begin
        run <= run + 1;
      end
    end else begin
      run <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill(input logic [11:0] w);
    for (int i = 0; i < 16; i++) imem[i] = w;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_halt(input int lim, inout int n);
    while (!halted && n < lim) begin
      tick();
      n++;
    end
  endtask

  int n, k, we0, ws0, il0, sb0, f0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(12'hF00);
    tick();

    // reset values
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_halt", halted, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_aluop", alu_op, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_req", imem_req, 0);

    // LDI r1,5; LDI r2,5; SUB r1,r2; HALT
    imem[0] = 12'h745;
    imem[1] = 12'h785;
    imem[2] = 12'h160;
    imem[3] = 12'hF00;
    we0 = n_we; ws0 = n_wsel; sb0 = n_sub; f0 = n_fetch;
    pulse_start();
    n = 0;
    run_halt(100, n);
    chk("p1_lat", n, 15);
    chk("p1_we", n_we - we0, 3);
    chk("p1_wsel", n_wsel - ws0, 2);
    chk("p1_sub", n_sub > sb0, 1);
    chk("p1_zero", zero, 1);
    chk("p1_halt", halted, 1);
    chk("p1_addr", imem_addr, 3);
    chk("p1_r1", rf[1], 0);
    chk("p1_r2", rf[2], 5);
    chk("p1_nf", n_fetch - f0, 4);
    tick();
    tick();
    chk("p1_frozen", imem_addr, 3);

    // delayed ack: LDI r0,9; HALT
    do_reset();
    fill(12'hF00);
    imem[0] = 12'h709;
    ack_dly = 3;
    we0 = n_we; f0 = n_fetch;
    pulse_start();
    n = 0;
    run_halt(100, n);
    chk("dly_lat", n, 13);
    chk("dly_run", last_run, 4);
    chk("dly_ir", n_fetch - f0, 2);
    chk("dly_we", n_we - we0, 1);
    chk("dly_r0", rf[0], 9);

    // 16 NOPs with PC wrap
    ack_dly = 0;
    do_reset();
    fill(12'hA00);
    we0 = n_we; il0 = n_ill; f0 = n_fetch;
    pulse_start();
    k = 0;
    while (n_fetch < f0 + 17 && k < 200) begin
      tick();
      k++;
    end
    chk("nop_done", k < 200, 1);
    for (int i = 0; i < 17; i++)
      chk($sformatf("nop_pc%0d", i), fa[f0 + i], i % 16);
    chk("nop_we", n_we - we0, 0);
    chk("nop_ill", n_ill - il0, 0);

    // reset while a fetch is outstanding
    ack_dly = 3;
    do_reset();
    pulse_start();
    k = 0;
    while (!(imem_req && imem_addr == 4'd2) && k < 100) begin
      tick();
      k++;
    end
    chk("mid_reach", k < 100, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_req", imem_req, 0);
    chk("mid_addr", imem_addr, 0);
    chk("mid_halt", halted, 0);
    tick();
    rst_n = 1'b1;
    f0 = n_fetch;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_idle", imem_req, 0);
    chk("mid_nf", n_fetch - f0, 0);

    // undefined 0xB, start during EXECUTE
    ack_dly = 0;
    do_reset();
    fill(12'hF00);
    imem[0] = 12'hB00;
    we0 = n_we; il0 = n_ill;
    pulse_start();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    run_halt(100, n);
    chk("ill_lat", n, 7);
    chk("ill_cnt", n_ill - il0, 1);
    chk("ill_we", n_we - we0, 0);
    chk("ill_addr", imem_addr, 1);

    // JZ 0xC with zero set
    do_reset();
    fill(12'hF00);
    imem[0] = 12'h745;
    imem[1] = 12'h785;
    imem[2] = 12'h160;
    imem[3] = 12'h90C;
    we0 = n_we; il0 = n_ill;
    pulse_start();
    n = 0;
    run_halt(100, n);
    chk("jzt_lat", n, 19);
    chk("jzt_addr", imem_addr, BR ? 12 : 4);
    chk("jzt_ill", n_ill - il0, BR ? 0 : 1);
    chk("jzt_we", n_we - we0, 3);

    // JZ 0xC with zero clear
    do_reset();
    fill(12'hF00);
    imem[0] = 12'h745;
    imem[1] = 12'h640;
    imem[2] = 12'h90C;
    il0 = n_ill;
    pulse_start();
    n = 0;
    run_halt(100, n);
    chk("jzn_zero", zero, 0);
    chk("jzn_addr", imem_addr, 3);
    chk("jzn_ill", n_ill - il0, BR ? 0 : 1);

    // JMP 5
    do_reset();
    fill(12'hF00);
    imem[0] = 12'h805;
    il0 = n_ill; we0 = n_we;
    pulse_start();
    n = 0;
    run_halt(100, n);
    chk("jmp_addr", imem_addr, BR ? 5 : 1);
    chk("jmp_ill", n_ill - il0, BR ? 0 : 1);
    chk("jmp_we", n_we - we0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit4.md
CTRL_UNIT4 -- requirements
Module: ctrl_unit4

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 start  input  1  one-cycle pulse; begins execution from PC 0.
REQ-004 imem_req / imem_addr  output  1 / 4  fetch request; instruction address (PC).
REQ-005 imem_ack / imem_data  input  1 / 12  fetch complete; instruction word {op[11:8], rd[7:6], rs[5:4], imm[3:0]}.
REQ-006 alu_op  output  3  operation select to the 4-bit ALU (000 ADD … 110 PASS A).
REQ-007 alu_result  input  4  ALU output, used only for the zero flag.
REQ-008 rf_ra, rf_rb, rf_wa  output  2 each  register-file read ports (rd, rs) and write address (rd).
REQ-009 rf_we / rf_wsel / imm  output  1 / 1 / 4  write strobe; write source (0 = ALU, 1 = imm); immediate.
REQ-010 zero / halted / illegal  output  1 each  zero flag; HALT state; one-cycle illegal-opcode pulse.

Function
REQ-011 FSM states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-012 IDLE/HALT + start -> FETCH with PC=0, zero=0; start in any other state ignored.
REQ-013 FETCH: imem_req=1, imem_addr=PC; stay until imem_ack=1; latch imem_data into IR -> DECODE; imem_ack outside FETCH ignored.
REQ-014 DECODE (1 cycle): rf_ra=IR.rd, rf_rb=IR.rs, imm=IR.imm registered; -> EXECUTE.
REQ-015 EXECUTE (1 cycle): op 0x0–0x6 drive alu_op=op[2:0]; other ops alu_op=000.
REQ-016 WRITEBACK (1 cycle): ALU ops rf_we=1, rf_wsel=0, zero<=(alu_result==0); LDI (0x7) rf_we=1, rf_wsel=1, zero unchanged.
REQ-017 PC increments mod 16 at WRITEBACK exit (15 -> 0) unless a taken jump loads it; -> FETCH.
REQ-018 NOP (0xA): no write, PC+1; HALT (0xF): -> HALT at EXECUTE exit, halted=1, PC frozen.
REQ-019 Undefined opcodes: treated as NOP; illegal=1 for exactly the WRITEBACK cycle.
REQ-020 rf_we asserted only in WRITEBACK, at most one cycle per instruction.
REQ-021 Latency: ALU/LDI instruction = fetch wait + 3 cycles; minimum 4 cycles with imem_ack same cycle as imem_req.

Reset
REQ-022 rst_n=0 immediately forces IDLE, PC=0, IR=0, zero=0, all outputs 0 (imem_req dropped mid-fetch).
REQ-023 After deassertion, block waits in IDLE for start.

Configuration
REQ-024 Macro CTRL_UNIT4_BRANCH_EN defined: JMP (0x8) PC<=imm; JZ (0x9) PC<=imm if zero=1 else PC+1; neither writes registers.
REQ-025 Macro undefined: 0x8 and 0x9 are undefined opcodes per REQ-019.

Structure
REQ-026 Package ctrl_unit4_pkg holds opcode constants, ALU op encodings, state enum, instruction field positions.
REQ-027 Sub-module ctrl_unit4_decode: combinational IR -> {alu_op, is_alu, is_ldi, is_jmp, is_jz, is_halt, is_illegal}.

Verification
REQ-028 Reset mid-FETCH (imem_req=1) -> imem_req=0, state IDLE, PC=0 in the same cycle as rst_n fall.
REQ-029 Program LDI r1,5; LDI r2,5; SUB r1,r2; HALT -> rf_we twice with rf_wsel=1, then alu_op=001, zero=1, halted=1, imem_addr=3.
REQ-030 imem_ack delayed 3 cycles -> imem_req held 4 cycles, IR latched once, no rf_we before ack.
REQ-031 16 NOPs from PC 0 -> imem_addr sequence 0..15 then 0 (wrap), no rf_we, no illegal.
REQ-032 BRANCH_EN: zero=1, JZ imm=0xC -> next imem_addr=0xC; zero=0 -> PC+1. Without macro: same word -> illegal pulse, PC+1.
REQ-033 Undefined opcode 0xB -> illegal=1 for one cycle, no rf_we, PC+1; start during EXECUTE ignored.
